// File: rtl/par_input_rx_if.sv
// Bus bundle for the parallel input receiver: CPU MMIO side plus the external 4-phase sender side.
interface par_input_rx_if;
    logic [15:0] ram_addr;
    logic [15:0] ram_write;
    logic        ram_op;
    logic [15:0] mmio_read;
    logic [7:0]  par_input_port;
    logic        par_input_signal;
    logic        par_input_ack;
    logic        rx_ready;

    modport slave (
        input  ram_addr, ram_write, ram_op, par_input_port, par_input_signal,
        output mmio_read, par_input_ack, rx_ready
    );

    modport master (
        output ram_addr, ram_write, ram_op, par_input_port, par_input_signal,
        input  mmio_read, par_input_ack, rx_ready
    );
endinterface

// File: rtl/par_input_rx.sv
// MMIO receiver for the parallel input port: synchronises a 4-phase sender, queues bytes in a
// small FIFO and exposes DATA/STATUS registers to the CPU.
module par_input_rx #(
    parameter int          DEPTH = 4,
    parameter logic [11:0] BASE  = 12'h200
) (
    input logic          clk,
    input logic          rst,
    par_input_rx_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {WAITLOW, IDLE, ACK} state_t;

    state_t          state, state_n;
    logic            sig_m, sig_s;
    logic [7:0]      dat_m, dat_s;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            full, nonempty, stalled;
    logic            hit_data, hit_stat, pop, flush, push;
    logic [7:0]      head;
    logic            ack_r, rdy_r;
    logic            unused_bits;

    // Signal flops reset high so a sender held high across reset reads as "still busy".
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_m <= 1'b1;
            sig_s <= 1'b1;
            dat_m <= 8'h00;
            dat_s <= 8'h00;
        end else begin
            sig_m <= bus.par_input_signal;
            sig_s <= sig_m;
            dat_m <= bus.par_input_port;
            dat_s <= dat_m;
        end
    end

    assign hit_data = bus.ram_addr[15] && (bus.ram_addr[11:0] == BASE);
    assign hit_stat = bus.ram_addr[15] && (bus.ram_addr[11:0] == BASE + 12'd1);
    assign full     = (count == CW'(DEPTH));
    assign nonempty = (count != '0);
    assign pop      = hit_data && bus.ram_op && nonempty;
    assign flush    = hit_stat && bus.ram_op && bus.ram_write[0];
    assign stalled  = (state == IDLE) && sig_s && full;

    always_comb begin
        state_n = state;
        push    = 1'b0;
        case (state)
            WAITLOW: if (!sig_s) state_n = IDLE;
            IDLE: begin
                // flush wins over capture; the byte is taken next cycle instead
                if (sig_s && !full && !flush) begin
                    push    = 1'b1;
                    state_n = ACK;
                end
            end
            ACK:     if (!sig_s) state_n = IDLE;
            default: state_n = WAITLOW;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAITLOW;
            ack_r <= 1'b0;
        end else begin
            state <= state_n;
            ack_r <= (state_n == ACK);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= dat_s;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rdy_r <= 1'b0;
        else     rdy_r <= nonempty;
    end

    assign head = nonempty ? mem[rd_ptr] : 8'h00;

    always_comb begin
        bus.mmio_read = 16'h0000;
        if (hit_data)      bus.mmio_read = {8'h00, head};
        else if (hit_stat) bus.mmio_read = {8'(count), 5'b0, stalled, full, nonempty};
    end

    assign bus.par_input_ack = ack_r;
    assign bus.rx_ready      = rdy_r;
    assign unused_bits       = ^{bus.ram_write[15:1], bus.ram_addr[14:12]};
endmodule

// File: tb/tb_par_input_rx.sv
// Directed bench for par_input_rx: a byte scoreboard filled on each acked send and drained
// through DATA reads, plus STATUS and handshake checks at the edges of interest.
module tb_par_input_rx;
    localparam logic [15:0] A_DATA = 16'h8200;
    localparam logic [15:0] A_STAT = 16'h8201;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [7:0] sb[$];

    par_input_rx_if bus();

    par_input_rx #(.DEPTH(4), .BASE(12'h200)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] d);
        bus.ram_addr = a;
        bus.ram_op   = 1'b0;
        #1;
        d = bus.mmio_read;
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
        logic [15:0] d;
        rd(a, d);
        chk(tag, d, exp);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        bus.ram_addr  = a;
        bus.ram_write = d;
        bus.ram_op    = 1'b1;
        tick();
        bus.ram_op    = 1'b0;
        bus.ram_addr  = 16'h0000;
    endtask

    task automatic wait_ack(input logic lvl, input string tag);
        int n = 0;
        while (bus.par_input_ack !== lvl && n < 20) begin
            tick();
            n++;
        end
        chk(tag, {15'b0, bus.par_input_ack}, {15'b0, lvl});
    endtask

    task automatic raise(input logic [7:0] b);
        bus.par_input_port   = b;
        bus.par_input_signal = 1'b1;
    endtask

    task automatic drop();
        bus.par_input_signal = 1'b0;
        wait_ack(1'b0, "ack_low");
    endtask

    task automatic send(input logic [7:0] b);
        raise(b);
        wait_ack(1'b1, "ack_high");
        sb.push_back(b);
        drop();
    endtask

    // Compare head against the scoreboard, then pop it.
    task automatic pop_chk(input string tag);
        logic [7:0] e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 16'h0001, 16'h0000);
            return;
        end
        e = sb.pop_front();
        rd_chk(tag, A_DATA, {8'h00, e});
        wr(A_DATA, 16'h0000);
    endtask

    task automatic drain(input string tag);
        while (sb.size() > 0) pop_chk(tag);
        rd_chk({tag, "_stat_empty"}, A_STAT, 16'h0000);
    endtask

    task automatic do_reset(input logic sig);
        rst = 1'b1;
        bus.par_input_signal = sig;
        repeat (3) tick();
        rst = 1'b0;
        sb.delete();
    endtask

    initial begin
        bus.ram_addr = 16'h0000;
        bus.ram_write = 16'h0000;
        bus.ram_op = 1'b0;
        bus.par_input_port = 8'h00;
        bus.par_input_signal = 1'b0;

        // 1: reset state, latency, STATUS/DATA, pop
        tick();
        do_reset(1'b0);
        chk("rst_ack", {15'b0, bus.par_input_ack}, 16'h0000);
        chk("rst_rdy", {15'b0, bus.rx_ready}, 16'h0000);
        rd_chk("rst_stat", A_STAT, 16'h0000);
        rd_chk("rst_data", A_DATA, 16'h0000);
        repeat (5) tick();
        raise(8'hA5);
        tick(); tick();
        chk("lat_e2_ack", {15'b0, bus.par_input_ack}, 16'h0000);
        tick();
        chk("lat_e3_ack", {15'b0, bus.par_input_ack}, 16'h0001);
        chk("lat_e3_rdy", {15'b0, bus.rx_ready}, 16'h0000);
        sb.push_back(8'hA5);
        rd_chk("t1_stat", A_STAT, 16'h0101);
        tick();
        chk("lat_e4_rdy", {15'b0, bus.rx_ready}, 16'h0001);
        drop();
        pop_chk("t1_data");
        rd_chk("t1_stat_after_pop", A_STAT, 16'h0000);
        tick();
        chk("t1_rdy_clr", {15'b0, bus.rx_ready}, 16'h0000);

        // 2: fill, stall, release by pop
        for (int i = 0; i < 4; i++) send(8'h11 + 8'(i));
        rd_chk("t2_full", A_STAT, 16'h0403);
        raise(8'h15);
        repeat (6) tick();
        chk("t2_no_ack", {15'b0, bus.par_input_ack}, 16'h0000);
        rd_chk("t2_stalled", A_STAT, 16'h0407);
        pop_chk("t2_pop1");
        wait_ack(1'b1, "t2_ack5");
        sb.push_back(8'h15);
        rd_chk("t2_head", A_DATA, {8'h00, sb[0]});
        drop();
        drain("t2_drain");

        // 3: sender held high through reset is ignored until it cycles
        bus.par_input_port = 8'h77;
        do_reset(1'b1);
        repeat (8) tick();
        chk("t3_ack_held", {15'b0, bus.par_input_ack}, 16'h0000);
        rd_chk("t3_stat_held", A_STAT, 16'h0000);
        bus.par_input_signal = 1'b0;
        repeat (4) tick();
        send(8'h3C);
        rd_chk("t3_one", A_STAT, 16'h0101);
        drain("t3_drain");

        // 4: push and pop on the same edge, order across pointer wrap
        send(8'h40);
        send(8'h41);
        raise(8'h42);
        tick(); tick();
        pop_chk("t4_simul_pop");
        chk("t4_simul_ack", {15'b0, bus.par_input_ack}, 16'h0001);
        sb.push_back(8'h42);
        rd_chk("t4_count2", A_STAT, 16'h0201);
        drop();
        for (int i = 3; i < 10; i++) begin
            send(8'h40 + 8'(i));
            pop_chk("t4_stream");
        end
        drain("t4_drain");

        // 5: flush collides with a push; push lands a cycle later
        send(8'h50);
        raise(8'h5A);
        tick(); tick();
        wr(A_STAT, 16'h0001);
        sb.delete();
        chk("t5_flush_ack", {15'b0, bus.par_input_ack}, 16'h0000);
        rd_chk("t5_flush_cnt", A_STAT, 16'h0000);
        tick();
        chk("t5_late_ack", {15'b0, bus.par_input_ack}, 16'h0001);
        sb.push_back(8'h5A);
        rd_chk("t5_late_cnt", A_STAT, 16'h0101);
        drop();
        wr(A_STAT, 16'h0002);
        rd_chk("t5_bit0_clr", A_STAT, 16'h0101);

        // 6: decode misses, alias on ignored bits, empty pop
        rd_chk("t6_8100", 16'h8100, 16'h0000);
        rd_chk("t6_0200", 16'h0200, 16'h0000);
        rd_chk("t6_8202", 16'h8202, 16'h0000);
        rd_chk("t6_alias", 16'hF200, 16'h005A);
        drain("t6_drain");
        wr(A_DATA, 16'h0000);
        rd_chk("t6_empty_pop", A_STAT, 16'h0000);
        send(8'h77);
        rd_chk("t6_after", A_STAT, 16'h0101);
        drain("t6_final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
